multi_queue_fifo: RTL
=====================

// Module: multi_queue_fifo
// PURPOSE
//   Parametrised successor to the single-queue fifo. Holds NUM_Q independent
//   FIFO queues in one storage array, with one write port and one read port.
//   Each port selects its queue per cycle. Adds per-queue full/empty bitmaps,
//   registered read data tagged with the queue id, and a write-while-full
//   drop flag. Used for per-core / per-requester buffering in the memory
//   interconnect.
// PARAMETERS
//   DATA_WIDTH    32  width of each entry
//   Q_DEPTH_BITS  3   log2 of per-queue depth (depth = 2**Q_DEPTH_BITS)
//   NUM_Q         4   number of queues, >=1
//   QSEL_W        localparam = (NUM_Q>1) ? $clog2(NUM_Q) : 1
// PORTS
//   clk          in   1           rising-edge clock
//   reset        in   1           synchronous, active-low reset
//   wr_q         in   QSEL_W      target queue of the write
//   write_data   in   DATA_WIDTH  data to enqueue
//   wrtEn        in   1           write request
//   rd_q         in   QSEL_W      source queue of the read or peek
//   rdEn         in   1           pop request
//   peek         in   1           read the head without popping
//   read_data    out  DATA_WIDTH  registered head data
//   valid        out  1           read_data/valid_q are valid this cycle
//   valid_q      out  QSEL_W      queue that read_data came from
//   full         out  NUM_Q       per-queue full, combinational from pointers
//   empty        out  NUM_Q       per-queue empty, combinational from pointers
//   wr_drop      out  1           registered pulse: last-cycle write was dropped
// BEHAVIOUR
//   - Reset (reset==0 at posedge): all pointers=0, so empty=all 1s, full=0.
//     read_data=0, valid=0, valid_q=0, wr_drop=0. Storage is not cleared.
//     Reset asserted mid-operation discards all contents.
//   - Pointers: each queue has rd/wr pointers of Q_DEPTH_BITS+1 bits that
//     wrap modulo 2**(Q_DEPTH_BITS+1).
//     empty[q]: pointers equal. full[q]: low bits equal, MSB differs.
//   - Write is accepted iff wrtEn && (!full[wr_q] || rd_accept_same).
//     rd_accept_same = rdEn accepted on the same queue in the same cycle.
//     On accept: entry stored at the write pointer, pointer incremented.
//     Otherwise the write is dropped and wr_drop=1 on the next cycle.
//   - Read is accepted iff (rdEn || peek) && !empty[rd_q]. A write in the
//     same cycle never makes an empty queue readable.
//   - Latency 1: on an accepted read, the next cycle has read_data = head of
//     rd_q, valid=1 and valid_q=rd_q. On rdEn the read pointer increments.
//     On peek only, the pointer is unchanged. rdEn and peek together are
//     treated as a pop.
//   - A rejected read (or no request): valid=0 next cycle; read_data and
//     valid_q hold their last values.
//   - Simultaneous read and write on different queues are independent.
//   - Same queue, full, rdEn+wrtEn: both are accepted and full stays 1.
//   - Same queue, empty, rdEn+wrtEn: write accepted, read rejected.
//   - wr_q/rd_q >= NUM_Q: the request is ignored. For writes, wr_drop pulses.
// CONFIGURATION
//   MQ_FIFO_LEVEL_EN
//   - Defined: adds output port level[(Q_DEPTH_BITS+1)-1:0], the
//     combinational occupancy of queue rd_q (wr_ptr - rd_ptr, 0..depth).
//   - Undefined: the port and its logic are absent. All else is identical.
// TESTING
//   1. Reset low 5 cycles -> empty=4'b1111, full=0, valid=0, read_data=0,
//      wr_drop=0.
//   2. Write 100 to q2; peek q2 -> next cycle valid=1, valid_q=2,
//      read_data=100, empty[2]=0. Then rdEn q2 -> read_data=100, valid=1,
//      empty[2]=1.
//   3. Write 8 values 10..17 to q1 -> full=4'b0010. Write 99 to q1 ->
//      wr_drop=1 next cycle. Pop 8 times -> 10..17 in order, empty[1]=1.
//   4. q0 full; rdEn+wrtEn(55) on q0 -> valid, old head returned, full[0]
//      stays 1, 55 is popped last.
//   5. rdEn on empty q3 with a same-cycle write of 7 to q3 -> valid=0. Next
//      rdEn q3 -> read_data=7.
//   6. Interleave write q0 (1,2) and q1 (3,4); pop q1, q0, q1, q0 -> 3,1,4,2
//      with valid_q 1,0,1,0. Reset mid-stream -> empty all 1s. With
//      MQ_FIFO_LEVEL_EN, level tracks 0..8.

Source files
------------

// File: rtl/multi_queue_fifo.sv
// NUM_Q independent FIFO queues sharing one storage array, with one write and one read port.
// Define MQ_FIFO_LEVEL_EN to add the `level` occupancy output for the queue selected by rd_q.
module multi_queue_fifo #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int Q_DEPTH_BITS = 3,
    parameter  int NUM_Q        = 4,
    localparam int QSEL_W       = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [QSEL_W-1:0]       wr_q,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    wrtEn,
    input  logic [QSEL_W-1:0]       rd_q,
    input  logic                    rdEn,
    input  logic                    peek,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    valid,
    output logic [QSEL_W-1:0]       valid_q,
    output logic [NUM_Q-1:0]        full,
    output logic [NUM_Q-1:0]        empty,
    output logic                    wr_drop
`ifdef MQ_FIFO_LEVEL_EN
    ,
    output logic [Q_DEPTH_BITS:0]   level
`endif
);

    localparam int PTR_W = Q_DEPTH_BITS + 1;
    localparam int DEPTH = 1 << Q_DEPTH_BITS;

    logic [DATA_WIDTH-1:0]   mem    [NUM_Q][DEPTH];
    logic [PTR_W-1:0]        wr_ptr [NUM_Q];
    logic [PTR_W-1:0]        rd_ptr [NUM_Q];

    logic                    wr_in_range, rd_in_range;
    logic                    wr_sel_full, rd_sel_empty;
    logic                    rd_accept, pop, wr_accept;
    logic [Q_DEPTH_BITS-1:0] wr_slot, rd_slot;

    // The extra pointer MSB separates full from empty when the slot bits match.
    always_comb begin
        for (int q = 0; q < NUM_Q; q++) begin
            empty[q] = (wr_ptr[q] == rd_ptr[q]);
            full[q]  = ((wr_ptr[q] ^ rd_ptr[q]) == PTR_W'(DEPTH));
        end
    end

    always_comb begin
        wr_in_range  = (32'(wr_q) < NUM_Q);
        rd_in_range  = (32'(rd_q) < NUM_Q);
        wr_sel_full  = wr_in_range ? full[wr_q]  : 1'b1;
        rd_sel_empty = rd_in_range ? empty[rd_q] : 1'b1;
        wr_slot      = Q_DEPTH_BITS'(wr_ptr[wr_q]);
        rd_slot      = Q_DEPTH_BITS'(rd_ptr[rd_q]);
        // Emptiness is judged before this cycle's write, so a write never feeds a same-cycle read.
        rd_accept    = (rdEn || peek) && !rd_sel_empty;
        pop          = rd_accept && rdEn;
        wr_accept    = wrtEn && wr_in_range && (!wr_sel_full || (pop && (rd_q == wr_q)));
    end

    // NOTE: storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_q][wr_slot] <= write_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values,
    // which lets a pop on a full queue return the old head while the same slot is rewritten.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int q = 0; q < NUM_Q; q++) begin
                wr_ptr[q] <= '0;
                rd_ptr[q] <= '0;
            end
            read_data <= '0;
            valid     <= 1'b0;
            valid_q   <= '0;
            wr_drop   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr[wr_q] <= wr_ptr[wr_q] + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr[rd_q] <= rd_ptr[rd_q] + PTR_W'(1);
            end
            valid <= rd_accept;
            if (rd_accept) begin
                read_data <= mem[rd_q][rd_slot];
                valid_q   <= rd_q;
            end
            wr_drop <= wrtEn && !wr_accept;
        end
    end

`ifdef MQ_FIFO_LEVEL_EN
    assign level = rd_in_range ? (wr_ptr[rd_q] - rd_ptr[rd_q]) : '0;
`endif

endmodule
